cpsr_pc_unit: RTL and testbench

- Status-register and program-counter stage downstream of the main opcode decoder; consumes its branch/jump/CPSR control lines and the ALU flags.
- Holds the 4-bit CPSR {N,Z,C,V} and the 32-bit PC.
- Resolves beq / bvf / ben / jump and registers the next PC every cycle.
- Feeds pc to instruction fetch; exposes the CPSR for debug.

---
 rtl/cpsr_pc_unit.sv | 106 ++++++++++
 tb/tb_cpsr_pc_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpsr_pc_unit.sv
// CPSR {N,Z,C,V} and program-counter stage: resolves beq/bvf/ben/jump and registers the next PC.
// Optional taken-redirect saturating counter enabled by defining BRANCH_STATS_EN.
module cpsr_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef BRANCH_STATS_EN
    ,
    parameter int STAT_WIDTH = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        b_format,
    input  logic        bvf,
    input  logic        ben,
    input  logic        j_format,
    input  logic        cpsr_update,
    input  logic        cpsr_reset,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_carry,
    input  logic        alu_ovf,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [3:0]  cpsr,
`ifdef BRANCH_STATS_EN
    output logic [STAT_WIDTH-1:0] taken_count,
`endif
    output logic        branch_taken
);

    logic [31:0] pc_q, pc_d;
    logic [3:0]  cpsr_q, cpsr_d;
    logic [31:0] btarget;
    logic [31:0] jaddr;
    logic        beq_t, bvf_t, ben_t;

    assign pc_plus4 = pc_q + 32'd4;
    assign btarget  = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jaddr    = {pc_plus4[31:28], jtarget, 2'b00};

    // Flag branches test the stored CPSR, not this instruction's ALU flags.
    assign beq_t = branch & alu_zero;
    assign bvf_t = b_format & bvf & cpsr_q[0];
    assign ben_t = b_format & ben & cpsr_q[3];

    assign branch_taken = j_format | beq_t | bvf_t | ben_t;

    always_comb begin
        pc_d   = pc_q;
        cpsr_d = cpsr_q;
        if (!stall) begin
            if (j_format) begin
                pc_d = jaddr;
            end else if (beq_t | bvf_t | ben_t) begin
                pc_d = btarget;
            end else begin
                pc_d = pc_plus4;
            end

            if (cpsr_reset) begin
                cpsr_d = 4'b0000;
            end else if (cpsr_update) begin
                cpsr_d = {alu_neg, alu_zero, alu_carry, alu_ovf};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            cpsr_q <= 4'b0000;
        end else begin
            pc_q   <= pc_d;
            cpsr_q <= cpsr_d;
        end
    end

    assign pc   = pc_q;
    assign cpsr = cpsr_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_WIDTH-1:0] taken_count_q, taken_count_d;

    always_comb begin
        taken_count_d = taken_count_q;
        if (!stall && branch_taken && (taken_count_q != {STAT_WIDTH{1'b1}})) begin
            taken_count_d = taken_count_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_count_q <= '0;
        end else begin
            taken_count_q <= taken_count_d;
        end
    end

    assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_cpsr_pc_unit.sv
// Self-checking bench for cpsr_pc_unit: directed walk through the main scenarios, then
// randomized control/flag stimulus checked against an arithmetic reference model.
module tb_cpsr_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0040;
    localparam int          SW     = 2;

    logic        clk = 1'b0;
    logic        reset, stall, branch, b_format, bvf, ben, j_format;
    logic        cpsr_update, cpsr_reset, alu_zero, alu_neg, alu_carry, alu_ovf;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] pc, pc_plus4;
    logic [3:0]  cpsr;
    logic        branch_taken;
`ifdef BRANCH_STATS_EN
    logic [SW-1:0] taken_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic [31:0] m_pc;
    logic [3:0]  m_cpsr;
    int          m_cnt;

    always #5 clk = ~clk;

    cpsr_pc_unit #(
        .RESET_PC(RST_PC)
`ifdef BRANCH_STATS_EN
        , .STAT_WIDTH(SW)
`endif
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .b_format(b_format),
        .bvf(bvf), .ben(ben), .j_format(j_format), .cpsr_update(cpsr_update),
        .cpsr_reset(cpsr_reset), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf), .imm16(imm16), .jtarget(jtarget),
        .pc(pc), .pc_plus4(pc_plus4), .cpsr(cpsr),
`ifdef BRANCH_STATS_EN
        .taken_count(taken_count),
`endif
        .branch_taken(branch_taken)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; branch = 0; b_format = 0; bvf = 0; ben = 0; j_format = 0;
        cpsr_update = 0; cpsr_reset = 0; alu_zero = 0; alu_neg = 0; alu_carry = 0;
        alu_ovf = 0; imm16 = '0; jtarget = '0;
    endtask

    function automatic logic model_taken();
        return j_format | (branch & alu_zero) |
               (b_format & bvf & m_cpsr[0]) | (b_format & ben & m_cpsr[3]);
    endfunction

    // Inputs are set just after a falling edge; this checks outputs, clocks once,
    // advances the model and returns just after the next falling edge.
    task automatic cycle();
        logic [31:0] pp4, nxt;
        logic        tk;
        int          off;
        #1;
        pp4 = m_pc + 32'd4;
        tk  = model_taken();
        off = int'($signed(imm16)) * 4;
        if (j_format)   nxt = {pp4[31:28], jtarget, 2'b00};
        else if (tk)    nxt = pp4 + 32'(off);
        else            nxt = pp4;
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, pp4);
        check("cpsr", {28'd0, cpsr}, {28'd0, m_cpsr});
        check("branch_taken", {31'd0, branch_taken}, {31'd0, tk});
`ifdef BRANCH_STATS_EN
        check("taken_count", {30'd0, taken_count}, 32'(m_cnt));
`endif
        @(posedge clk);
        if (reset) begin
            m_pc = RST_PC; m_cpsr = 4'd0; m_cnt = 0;
        end else if (!stall) begin
            m_pc = nxt;
            if (cpsr_reset)       m_cpsr = 4'd0;
            else if (cpsr_update) m_cpsr = {alu_neg, alu_zero, alu_carry, alu_ovf};
            if (tk && m_cnt < (1 << SW) - 1) m_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        m_pc = 'x; m_cpsr = 'x; m_cnt = 0;
        idle();
        @(negedge clk);
        // reset: the model is unknown until the first edge, so clock twice without checks
        reset = 1;
        @(posedge clk); @(posedge clk);
        m_pc = RST_PC; m_cpsr = 0; m_cnt = 0;
        @(negedge clk);
        #1;
        check("reset_pc", pc, 32'h40);
        check("reset_cpsr", {28'd0, cpsr}, 32'd0);
        idle();
        cycle(); check("seq_44", pc, 32'h44);
        cycle(); check("seq_48", pc, 32'h48);

        // beq to 0x100, then backward beq (-2 words) and a not-taken beq
        branch = 1; alu_zero = 1; imm16 = 16'h002D; cycle();
        check("beq_to_100", pc, 32'h100);
        imm16 = 16'hFFFE; cycle();
        check("beq_back", pc, 32'h0FC);
        alu_zero = 0; cycle();
        check("beq_not_taken", pc, 32'h100);
        idle();

        // load flags N,V while jumping to 0x200, then bvf taken-and-clear, then bvf not taken
        cpsr_update = 1; alu_ovf = 1; alu_neg = 1; j_format = 1; jtarget = 26'h80; cycle();
        check("cpsr_1001", {28'd0, cpsr}, 32'h9);
        check("jump_200", pc, 32'h200);
        idle();
        b_format = 1; bvf = 1; cpsr_reset = 1; imm16 = 16'd3; cycle();
        check("bvf_taken", pc, 32'h210);
        check("bvf_cleared", {28'd0, cpsr}, 32'd0);
        cycle();
        check("bvf_second", pc, 32'h214);
        idle();

        // reach 0xFFFF_FFF0, then jump+beq together: jump wins
        branch = 1; alu_zero = 1; imm16 = 16'hFF76; cycle();
        check("beq_high", pc, 32'hFFFF_FFF0);
        j_format = 1; jtarget = 26'h0000123; cycle();
        check("jump_priority", pc, 32'hF000_048C);
        idle();
        j_format = 1; jtarget = 26'h3FF_FFFF; cycle();
        check("jump_top", pc, 32'hFFFF_FFFC);
        idle(); cycle();
        check("pc_wrap", pc, 32'h0);

        // stall holds everything, release updates, reset overrides stall
        stall = 1; cpsr_update = 1; {alu_neg, alu_zero, alu_carry, alu_ovf} = 4'hF;
        j_format = 1; jtarget = 26'h55;
        repeat (3) cycle();
        check("stall_pc", pc, 32'h0);
        check("stall_cpsr", {28'd0, cpsr}, 32'd0);
        stall = 0; j_format = 0; cycle();
        check("release_cpsr", {28'd0, cpsr}, 32'hF);
        check("release_pc", pc, 32'h4);
        stall = 1; reset = 1; cycle();
        check("reset_in_stall_pc", pc, RST_PC);
        check("reset_in_stall_cpsr", {28'd0, cpsr}, 32'd0);
        idle();

        // five taken redirects and one stalled taken redirect
        j_format = 1; jtarget = 26'h10;
        repeat (5) cycle();
        stall = 1; cycle();
`ifdef BRANCH_STATS_EN
        #1; check("count_saturated", {30'd0, taken_count}, 32'd3);
`endif
        idle();

        // randomized
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 49) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            branch      = ($urandom_range(0, 3) == 0);
            b_format    = ($urandom_range(0, 2) == 0);
            bvf         = $urandom_range(0, 1) == 1;
            ben         = $urandom_range(0, 1) == 1;
            j_format    = ($urandom_range(0, 7) == 0);
            cpsr_update = $urandom_range(0, 1) == 1;
            cpsr_reset  = ($urandom_range(0, 3) == 0);
            {alu_neg, alu_zero, alu_carry, alu_ovf} = 4'($urandom);
            imm16       = 16'($urandom);
            jtarget     = 26'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
